regfile_write_arbiter: RTL

Shares the register file's single write port among NUM_REQ writeback sources (ALU, multiply/divide unit, load path) using round-robin arbitration. It drives the per-register write enables and common data into the register file's 32 enable flip-flop rows. Writes to register 0 are accepted but never enabled. Losing requesters are back-pressured by withholding their grant.

---
 rtl/rf_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared register-file constants, write-stage state encoding and
//            the round-robin pointer helper.
// Revision : 1.0  initial release
// ============================================================================
package rf_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
  // Architectural zero register: writes are accepted but never enabled.
  localparam int ZERO_REG  = 0;

  // Write-stage state: WRITE means a write (or a register-0 discard) is
  // currently registered on the wr_* outputs.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // Priority pointer value after requester idx wins among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational N-way round-robin pick. Search starts at i_ptr and
//            wraps modulo NUM_REQ; emits a one-hot grant and the winner index.
//            The priority pointer register lives in the parent.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_hold,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_win,
  output logic               o_valid
);

  int w_idx;

  // Scan offsets from farthest to nearest so the requester closest to the
  // pointer is the last assignment and therefore the winner.
  always_comb begin
    o_gnt   = '0;
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    if (!i_hold) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        w_idx = (int'(i_ptr) + off) % NUM_REQ;
        if (i_req[w_idx]) begin
          o_gnt        = '0;
          o_gnt[w_idx] = 1'b1;
          o_win        = PTR_W'(w_idx);
          o_valid      = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares the register file's single write port among NUM_REQ
//            writeback sources with round-robin arbitration. Drives one-hot
//            row enables plus common data; register 0 is never enabled.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W  = rf_pkg::DATA_W,
  parameter int ADDR_W  = rf_pkg::ADDR_W,
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [2**ADDR_W-1:0]      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data
);

  import rf_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]   r_ptr;
  wr_state_t          r_state;
  logic [NREG-1:0]    r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  logic               w_block;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_win;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [NREG-1:0]    w_dec;

  // Reset also blocks grants so requesters never see gnt while clr_n is low.
  assign w_block = hold | ~clr_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_hold  (w_block),
    .o_gnt   (w_gnt),
    .o_win   (w_win),
    .o_valid (w_xfer)
  );

  assign gnt = w_gnt;

  // Select the winner's address and data with the one-hot grant.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot row decode; the zero register row is never enabled.
  generate
    for (genvar r = 0; r < NREG; r++) begin : g_dec
      if (r == ZERO_REG) begin : g_zero
        assign w_dec[r] = 1'b0;
      end else begin : g_row
        assign w_dec[r] = (w_addr == ADDR_W'(r));
      end
    end
  endgenerate

  // Priority pointer: moves just past the winner on every transfer.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= PTR_W'(rr_next(int'(w_win), NUM_REQ));
    end
  end

  // Write stage FSM: re-evaluated every cycle so back-to-back transfers
  // stay in WRITE and sustain one write per cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_xfer) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= w_dec;
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
          end else begin
            r_state <= ST_IDLE;
            r_wr_en <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= '0;
        end
      endcase
    end
  end

  // Enables are only presented while a write is registered.
  assign wr_en   = (r_state == ST_WRITE) ? r_wr_en : '0;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
`default_nettype wire
